masked_share_unmasker: RTL and testbench

- Receiving end of the two-share masked datapath: accepts the two Boolean shares of one masked word as separate handshaked beats on a single share bus and recombines them (data = share0 ^ share1) into a plaintext output word.
- Shares are never combined combinationally on arrival. Each share is registered in its own domain, the output register is held at zero for a programmable clear window, and only then is the recombination XOR latched.
- Sits at the unmasking boundary after masked gadgets, feeding plaintext consumers and the leakage-evaluation benches.

---
 rtl/masked_share_unmasker_if.sv | 22 ++
 rtl/masked_share_unmasker.sv | 114 +++++++++++
 tb/tb_masked_share_unmasker.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/masked_share_unmasker_if.sv
// masked_share_unmasker_if: share-beat input bus and recombined-word output bus
interface masked_share_unmasker_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_idx;
    logic [WIDTH-1:0] in_share;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_idx, in_share, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_idx, in_share, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/masked_share_unmasker.sv
// masked_share_unmasker: registers two Boolean shares separately and recombines them after a zeroed clear window
module masked_share_unmasker #(
    parameter int WIDTH        = 4,
    parameter int CLEAR_CYCLES = 1,
    parameter int CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    masked_share_unmasker_if.slave bus,
    output logic                 err_o,
    output logic [CNT_W-1:0]     word_count_o,
    output logic [CNT_W-1:0]     err_count_o
);
    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_S1, CLEAR, COMBINE, OUT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, od_q, od_d;
    logic             ov_q, ov_d, err_q, err_d;
    logic [CNT_W-1:0] wc_q, wc_d, ec_q, ec_d, ec_inc;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;

    assign bus.in_ready  = (state_q == IDLE) || (state_q == WAIT_S1);
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign err_o         = err_q;
    assign word_count_o  = wc_q;
    assign err_count_o   = ec_q;
    assign accept        = bus.in_valid & bus.in_ready;
    assign ec_inc        = (&ec_q) ? ec_q : ec_q + 1'b1;

    // State and datapath registers; every register clears on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s0_q    <= '0;
            s1_q    <= '0;
            od_q    <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
            wc_q    <= '0;
            ec_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            od_q    <= od_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
            wc_q    <= wc_d;
            ec_q    <= ec_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: shares land in separate registers; the XOR happens only in COMBINE after the clear window
    always_comb begin
        state_d = state_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        od_d    = od_q;
        ov_d    = ov_q;
        err_d   = 1'b0;
        wc_d    = wc_q;
        ec_d    = ec_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && !bus.in_idx) begin
                    s0_d    = bus.in_share;
                    state_d = WAIT_S1;
                end else if (accept) begin
                    err_d = 1'b1;
                    ec_d  = ec_inc;
                end
            end
            WAIT_S1: begin
                if (accept && bus.in_idx) begin
                    s1_d    = bus.in_share;
                    cnt_d   = CW'(CLEAR_CYCLES - 1);
                    state_d = (CLEAR_CYCLES > 0) ? CLEAR : COMBINE;
                end else if (accept) begin
                    s0_d  = bus.in_share;
                    err_d = 1'b1;
                    ec_d  = ec_inc;
                end
            end
            CLEAR: begin
                od_d    = '0;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? COMBINE : CLEAR;
            end
            COMBINE: begin
                od_d    = s0_q ^ s1_q;
                ov_d    = 1'b1;
                s0_d    = '0;
                s1_d    = '0;
                state_d = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    ov_d    = 1'b0;
                    od_d    = '0;
                    wc_d    = wc_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_masked_share_unmasker.sv
// tb_masked_share_unmasker: directed and random share pairs on three configurations against a pairing-rule model
module tb_masked_share_unmasker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic       v[3], idx[3], ordy[3];
    logic [3:0] sh[3];
    logic       rdy[3], ov[3], er[3];
    logic [3:0] od[3];
    logic [7:0] wc[3], ec[3];

    int clr[3] = '{1, 0, 1};
    int msk[3] = '{255, 255, 3};
    int wc_exp[3], ec_exp[3];
    bit have[3];
    logic [3:0] s0m[3];

    for (genvar g = 0; g < 3; g++) begin : dut_g
        localparam int CNW = (g == 2) ? 2 : 8;
        logic [CNW-1:0] wcl, ecl;
        masked_share_unmasker_if #(.WIDTH(4)) bus ();
        masked_share_unmasker #(
            .WIDTH(4), .CLEAR_CYCLES((g == 1) ? 0 : 1), .CNT_W(CNW)
        ) dut (
            .clk(clk), .rst(rst), .bus(bus.slave),
            .err_o(er[g]), .word_count_o(wcl), .err_count_o(ecl)
        );
        assign bus.in_valid  = v[g];
        assign bus.in_idx    = idx[g];
        assign bus.in_share  = sh[g];
        assign bus.out_ready = ordy[g];
        assign rdy[g]        = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign od[g]         = bus.out_data;
        assign wc[g]         = 8'(wcl);
        assign ec[g]         = 8'(ecl);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, int u, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, u, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            wc_exp[u] = 0;
            ec_exp[u] = 0;
            have[u]   = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            v[u] = 0; idx[u] = 0; sh[u] = 0; ordy[u] = 0;
        end
        step();
        step();
        rst = 1'b0;
        model_reset();
        for (int u = 0; u < 3; u++) begin
            chk("rst_ready", u, rdy[u], 1);
            chk("rst_valid", u, ov[u], 0);
            chk("rst_data", u, od[u], 0);
            chk("rst_err", u, er[u], 0);
            chk("rst_wc", u, wc[u], 0);
            chk("rst_ec", u, ec[u], 0);
        end
    endtask

    task automatic send(int u, logic i, logic [3:0] s);
        int n = 0;
        bit viol;
        v[u] = 1; idx[u] = i; sh[u] = s;
        while (!rdy[u] && n < 20) begin
            step();
            n++;
        end
        chk("send_ready", u, rdy[u], 1);
        step();
        v[u] = 0; idx[u] = 1'($urandom); sh[u] = 4'($urandom);
        viol = i ? !have[u] : have[u];
        if (!i) s0m[u] = s;
        have[u] = !i;
        if (viol) ec_exp[u] = (ec_exp[u] == msk[u]) ? msk[u] : ec_exp[u] + 1;
        chk("err_pulse", u, er[u], viol);
        chk("err_count", u, ec[u], ec_exp[u]);
    endtask

    task automatic finish(int u, logic [3:0] s1, int hold);
        logic [3:0] exp;
        int n = 0;
        exp = s0m[u] ^ s1;
        ordy[u] = (hold == 0);
        send(u, 1, s1);
        while (!ov[u] && n < 20) begin
            chk("clear_zero", u, od[u], 0);
            chk("busy_ready", u, rdy[u], 0);
            step();
            n++;
        end
        chk("latency", u, n, clr[u] + 1);
        chk("data", u, od[u], exp);
        for (int h = 0; h < hold; h++) begin
            v[u] = 1; idx[u] = 1'($urandom); sh[u] = 4'($urandom);
            step();
            chk("hold_valid", u, ov[u], 1);
            chk("hold_data", u, od[u], exp);
            chk("hold_ready", u, rdy[u], 0);
        end
        v[u] = 0;
        ordy[u] = 1;
        step();
        ordy[u] = 0;
        wc_exp[u] = (wc_exp[u] + 1) & msk[u];
        chk("done_valid", u, ov[u], 0);
        chk("done_data", u, od[u], 0);
        chk("done_ready", u, rdy[u], 1);
        chk("done_err", u, er[u], 0);
        chk("word_count", u, wc[u], wc_exp[u]);
    endtask

    task automatic word(int u, logic [3:0] s0, logic [3:0] s1, int hold);
        send(u, 0, s0);
        finish(u, s1, hold);
    endtask

    initial begin
        do_reset();
        word(0, 4'hA, 4'h6, 0);
        chk("first_word", 0, od[0] ^ 4'hC ^ 4'hC, 4'h0);
        word(0, 4'hA, 4'h6, 5);
        send(0, 1, 4'h3);
        send(0, 1, 4'h7);
        send(0, 0, 4'h1);
        send(0, 0, 4'h5);
        finish(0, 4'h5, 0);
        word(1, 4'hF, 4'h1, 0);
        send(0, 0, 4'h9);
        send(0, 1, 4'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            chk("rst_clear_valid", 0, ov[0], 0);
            chk("rst_clear_data", 0, od[0], 0);
            chk("rst_clear_wc", 0, wc[0], 0);
            chk("rst_clear_ec", 0, ec[0], 0);
            chk("rst_clear_err", 0, er[0], 0);
            step();
        end
        word(0, 4'h9, 4'h2, 0);
        for (int k = 0; k < 30; k++) begin
            int r;
            r = int'($urandom_range(0, 3));
            if (r == 0) send(0, 1, 4'($urandom));
            if (r == 1) send(0, 0, 4'($urandom));
            if (r == 1) finish(0, 4'($urandom), int'($urandom_range(0, 3)));
            else word(0, 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
        end
        for (int k = 0; k < 5; k++) word(2, 4'($urandom), 4'($urandom), k % 2);
        for (int k = 0; k < 5; k++) send(2, 1, 4'($urandom));
        chk("wrap_wc", 2, wc[2], 1);
        chk("sat_ec", 2, ec[2], 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
